// File: rtl/cle_unlock_seq_if.sv
// CPU-side bus bundle for the unlock sequencer: bus-cycle qualifier, address,
// direction and the registered status/strobe outputs back to the system.
// ba carries CPU address bits [13:4]: ba[9] = A13, ba[8] = A12, ba[3:0] = A[7:4].
interface cle_unlock_seq_if;
   logic       bus_valid;
   logic       sser;
   logic [9:0] ba;
   logic       br_w;
   logic       sdrd;
   logic       data_oe;
   logic [3:0] rd_sel;
   logic       unlocked;
   logic       overrun;
   logic [2:0] state;

   modport master (
      output bus_valid, sser, ba, br_w,
      input  sdrd, data_oe, rd_sel, unlocked, overrun, state
   );

   modport slave (
      input  bus_valid, sser, ba, br_w,
      output sdrd, data_oe, rd_sel, unlocked, overrun, state
   );
endinterface

// File: rtl/cle_unlock_seq.sv
// Four-nibble unlock sequencer guarding a serial-device window. After the key
// reads KEY0..KEY3 the window opens: reads at nib 0 fire a fixed-length sdrd
// strobe, nib F relocks, any other nib latches a one-cycle register read.
// An idle counter relocks the window after TIMEOUT cycles without a hit.
module cle_unlock_seq #(
   parameter logic [3:0] KEY0      = 4'h2,
   parameter logic [3:0] KEY1      = 4'hA,
   parameter logic [3:0] KEY2      = 4'hB,
   parameter logic [3:0] KEY3      = 4'h9,
   parameter int         TIMEOUT   = 200,
   parameter int         PULSE_LEN = 3
) (
   input logic              clk,
   input logic              rst,
   cle_unlock_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_LOCKED = 3'd0,
      ST_K1     = 3'd1,
      ST_K2     = 3'd2,
      ST_K3     = 3'd3,
      ST_OPEN   = 3'd4,
      ST_STROBE = 3'd5
   } state_t;

   // Last idle count before relock, and the strobe counter load value.
   localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

   state_t     state_q, state_d;
   logic [7:0] idle_q, idle_d;
   logic [3:0] strb_q, strb_d;
   logic       sdrd_q, sdrd_d;
   logic       data_oe_q, data_oe_d;
   logic [3:0] rd_sel_q, rd_sel_d;
   logic       unlocked_q, unlocked_d;
   logic       overrun_q, overrun_d;

   logic       hit;
   logic [3:0] nib;
   logic       unused_ba;

   assign hit       = bus.bus_valid & ~bus.sser & ~bus.ba[9] & bus.ba[8];
   assign nib       = bus.ba[3:0];
   // Address bits A[11:8] do not take part in decoding.
   assign unused_ba = ^bus.ba[7:4];

   // One step of the key sequence: advance on the expected read, restart at
   // K1 when the read happens to be the first key, otherwise fall back.
   function automatic state_t key_step(input logic br_w, input logic [3:0] n,
                                       input logic [3:0] expect_key,
                                       input state_t adv);
      if (br_w && n == expect_key) return adv;
      if (br_w && n == KEY0)       return ST_K1;
      return ST_LOCKED;
   endfunction

   // Next-state and next-output decode for the whole sequencer.
   always_comb begin
      state_d   = state_q;
      idle_d    = idle_q;
      strb_d    = strb_q;
      sdrd_d    = 1'b0;
      data_oe_d = 1'b0;
      rd_sel_d  = rd_sel_q;
      overrun_d = overrun_q;

      case (state_q)
         ST_LOCKED: if (hit) state_d = key_step(bus.br_w, nib, KEY0, ST_K1);
         ST_K1:     if (hit) state_d = key_step(bus.br_w, nib, KEY1, ST_K2);
         ST_K2:     if (hit) state_d = key_step(bus.br_w, nib, KEY2, ST_K3);
         ST_K3: begin
            if (hit) begin
               state_d = key_step(bus.br_w, nib, KEY3, ST_OPEN);
               idle_d  = 8'd0;
            end
         end
         ST_OPEN: begin
            if (hit) begin
               // A hit always wins over an expiring timeout.
               idle_d = 8'd0;
               if (!bus.br_w) begin
                  state_d = ST_LOCKED;
               end else if (nib == 4'h0) begin
                  state_d = ST_STROBE;
                  sdrd_d  = 1'b1;
                  strb_d  = PULSE_LAST;
               end else if (nib == 4'hF) begin
                  state_d   = ST_LOCKED;
                  overrun_d = 1'b0;
               end else begin
                  data_oe_d = 1'b1;
                  rd_sel_d  = nib;
               end
            end else if (idle_q == IDLE_LAST) begin
               state_d = ST_LOCKED;
               idle_d  = 8'd0;
            end else if (idle_q != 8'hFF) begin
               idle_d = idle_q + 8'd1;
            end
         end
         ST_STROBE: begin
            // Hits here are dropped; the pulse length is fixed once started.
            if (hit) overrun_d = 1'b1;
            if (strb_q == 4'd0) begin
               state_d = ST_OPEN;
               idle_d  = 8'd0;
            end else begin
               strb_d = strb_q - 4'd1;
               sdrd_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_LOCKED;
            idle_d  = 8'd0;
            strb_d  = 4'd0;
         end
      endcase

      unlocked_d = (state_d == ST_OPEN) || (state_d == ST_STROBE);
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_LOCKED;
         idle_q     <= 8'd0;
         strb_q     <= 4'd0;
         sdrd_q     <= 1'b0;
         data_oe_q  <= 1'b0;
         rd_sel_q   <= 4'd0;
         unlocked_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idle_q     <= idle_d;
         strb_q     <= strb_d;
         sdrd_q     <= sdrd_d;
         data_oe_q  <= data_oe_d;
         rd_sel_q   <= rd_sel_d;
         unlocked_q <= unlocked_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.state    = state_q;
   assign bus.sdrd     = sdrd_q;
   assign bus.data_oe  = data_oe_q;
   assign bus.rd_sel   = rd_sel_q;
   assign bus.unlocked = unlocked_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_cle_unlock_seq.sv
// Bench for cle_unlock_seq: vector table replayed through a scoreboard queue,
// followed by hand-written timeout and mid-strobe reset sequences.
module tb_cle_unlock_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cle_unlock_seq_if bus_if ();

   cle_unlock_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic       sser;
      logic [9:0] ba;
      logic       brw;
      logic [2:0] st;
      logic       sdrd;
      logic       doe;
      logic [3:0] rs;
      logic       unl;
      logic       ovr;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   total  = 0;
   int   passed = 0;
   int   row    = 0;

   function automatic logic [9:0] hba(input logic [3:0] n);
      return {2'b01, 4'h0, n};
   endfunction

   function automatic vec_t mk(input logic vld, input logic sser, input logic [9:0] ba,
                               input logic brw, input logic [2:0] st, input logic sdrd,
                               input logic doe, input logic [3:0] rs, input logic unl,
                               input logic ovr);
      vec_t v;
      v.vld = vld; v.sser = sser; v.ba = ba; v.brw = brw;
      v.st = st; v.sdrd = sdrd; v.doe = doe; v.rs = rs; v.unl = unl; v.ovr = ovr;
      return v;
   endfunction

   // Read hit with expected outputs.
   function automatic vec_t rd(input logic [3:0] n, input logic [2:0] st, input logic sdrd,
                               input logic doe, input logic [3:0] rs, input logic unl,
                               input logic ovr);
      return mk(1'b1, 1'b0, hba(n), 1'b1, st, sdrd, doe, rs, unl, ovr);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act,
                      input logic [7:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, expv);
   endtask

   task automatic drive(input vec_t v);
      bus_if.bus_valid = v.vld;
      bus_if.sser      = v.sser;
      bus_if.ba        = v.ba;
      bus_if.br_w      = v.brw;
      exp_q.push_back(v);
   endtask

   task automatic sample();
      vec_t e;
      row++;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", row, 8'd1, 8'd0);
         return;
      end
      e = exp_q.pop_front();
      chk("state",    row, 8'(bus_if.state),    8'(e.st));
      chk("sdrd",     row, 8'(bus_if.sdrd),     8'(e.sdrd));
      chk("data_oe",  row, 8'(bus_if.data_oe),  8'(e.doe));
      chk("rd_sel",   row, 8'(bus_if.rd_sel),   8'(e.rs));
      chk("unlocked", row, 8'(bus_if.unlocked), 8'(e.unl));
      chk("overrun",  row, 8'(bus_if.overrun),  8'(e.ovr));
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus_if.bus_valid = 1'b0;
         @(posedge clk);
      end
      #1;
   endtask

   task automatic unlock(input logic [3:0] rs, input logic ovr);
      apply(rd(4'h2, 3'd1, 1'b0, 1'b0, rs, 1'b0, ovr));
      apply(rd(4'hA, 3'd2, 1'b0, 1'b0, rs, 1'b0, ovr));
      apply(rd(4'hB, 3'd3, 1'b0, 1'b0, rs, 1'b0, ovr));
      apply(rd(4'h9, 3'd4, 1'b0, 1'b0, rs, 1'b1, ovr));
   endtask

   initial begin
      bus_if.bus_valid = 1'b0;
      bus_if.sser      = 1'b1;
      bus_if.ba        = 10'd0;
      bus_if.br_w      = 1'b1;

      // Key sequence, restarts and fallbacks, then the OPEN-state commands.
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, 0, hba(4'hA), 1, 3'd1, 0, 0, 4'h0, 0, 0));          // no bus_valid
      tbl.push_back(mk(1, 1, hba(4'hA), 1, 3'd1, 0, 0, 4'h0, 0, 0));          // deselected
      tbl.push_back(mk(1, 0, {2'b11, 4'h0, 4'hA}, 1, 3'd1, 0, 0, 4'h0, 0, 0)); // A13 set
      tbl.push_back(mk(1, 0, {2'b00, 4'h0, 4'hA}, 1, 3'd1, 0, 0, 4'h0, 0, 0)); // A12 clear
      tbl.push_back(rd(4'hA, 3'd2, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'h7, 3'd0, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h0, 0, 0));
      tbl.push_back(mk(1, 0, hba(4'h2), 0, 3'd0, 0, 0, 4'h0, 0, 0));          // write in K1
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'hA, 3'd2, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'hB, 3'd3, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h0, 0, 0));                        // KEY0 in K3
      tbl.push_back(rd(4'hA, 3'd2, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'hB, 3'd3, 0, 0, 4'h0, 0, 0));
      tbl.push_back(rd(4'h9, 3'd4, 0, 0, 4'h0, 1, 0));
      tbl.push_back(rd(4'h5, 3'd4, 0, 1, 4'h5, 1, 0));
      tbl.push_back(mk(0, 0, hba(4'h0), 1, 3'd4, 0, 0, 4'h5, 1, 0));
      tbl.push_back(rd(4'h0, 3'd5, 1, 0, 4'h5, 1, 0));
      tbl.push_back(rd(4'h3, 3'd5, 1, 0, 4'h5, 1, 1));                        // hit mid-strobe
      tbl.push_back(mk(0, 0, hba(4'h0), 1, 3'd5, 1, 0, 4'h5, 1, 1));
      tbl.push_back(mk(0, 0, hba(4'h0), 1, 3'd4, 0, 0, 4'h5, 1, 1));
      tbl.push_back(mk(1, 0, hba(4'h5), 0, 3'd0, 0, 0, 4'h5, 0, 1));          // write in OPEN
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h5, 0, 1));
      tbl.push_back(rd(4'hA, 3'd2, 0, 0, 4'h5, 0, 1));
      tbl.push_back(rd(4'hB, 3'd3, 0, 0, 4'h5, 0, 1));
      tbl.push_back(rd(4'h9, 3'd4, 0, 0, 4'h5, 1, 1));
      tbl.push_back(rd(4'hF, 3'd0, 0, 0, 4'h5, 0, 0));
      tbl.push_back(rd(4'h2, 3'd1, 0, 0, 4'h5, 0, 0));
      tbl.push_back(rd(4'hA, 3'd2, 0, 0, 4'h5, 0, 0));
      tbl.push_back(rd(4'hB, 3'd3, 0, 0, 4'h5, 0, 0));
      tbl.push_back(rd(4'h9, 3'd4, 0, 0, 4'h5, 1, 0));
      tbl.push_back(rd(4'h3, 3'd4, 0, 1, 4'h3, 1, 0));
      tbl.push_back(mk(1, 0, {2'b11, 4'h0, 4'hF}, 1, 3'd4, 0, 0, 4'h3, 1, 0)); // non-hit F

      // Reset state while rst is held with the clock running.
      repeat (3) @(negedge clk);
      chk("rst_state",    0, 8'(bus_if.state),    8'd0);
      chk("rst_sdrd",     0, 8'(bus_if.sdrd),     8'd0);
      chk("rst_data_oe",  0, 8'(bus_if.data_oe),  8'd0);
      chk("rst_rd_sel",   0, 8'(bus_if.rd_sel),   8'd0);
      chk("rst_unlocked", 0, 8'(bus_if.unlocked), 8'd0);
      chk("rst_overrun",  0, 8'(bus_if.overrun),  8'd0);
      rst = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);

      // Timeout: OPEN for 199 idle cycles after a hit, relock on the 200th.
      apply(rd(4'h4, 3'd4, 0, 1, 4'h4, 1, 0));
      idle(199);
      chk("timeout_open_199", row, 8'(bus_if.state), 8'd4);
      idle(1);
      chk("timeout_locked_200", row, 8'(bus_if.state), 8'd0);
      chk("timeout_unlocked", row, 8'(bus_if.unlocked), 8'd0);

      // Hit on the very cycle the timeout would fire is serviced instead.
      unlock(4'h4, 1'b0);
      idle(199);
      chk("late_open", row, 8'(bus_if.state), 8'd4);
      apply(rd(4'h6, 3'd4, 0, 1, 4'h6, 1, 0));
      idle(199);
      chk("rearm_open_199", row, 8'(bus_if.state), 8'd4);
      idle(1);
      chk("rearm_locked_200", row, 8'(bus_if.state), 8'd0);

      // Reset between clock edges in the middle of a strobe.
      unlock(4'h6, 1'b0);
      apply(rd(4'h0, 3'd5, 1, 0, 4'h6, 1, 0));
      apply(rd(4'h8, 3'd5, 1, 0, 4'h6, 1, 1));
      #2;
      rst = 1'b1;
      bus_if.bus_valid = 1'b0;
      #1;
      chk("midrst_sdrd",     row, 8'(bus_if.sdrd),     8'd0);
      chk("midrst_state",    row, 8'(bus_if.state),    8'd0);
      chk("midrst_unlocked", row, 8'(bus_if.unlocked), 8'd0);
      chk("midrst_overrun",  row, 8'(bus_if.overrun),  8'd0);
      chk("midrst_rd_sel",   row, 8'(bus_if.rd_sel),   8'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(rd(4'h2, 3'd1, 0, 0, 4'h0, 0, 0));
      @(posedge clk);
      #1;
      sample();
      apply(mk(0, 0, hba(4'h0), 1, 3'd1, 0, 0, 4'h0, 0, 0));

      chk("scoreboard_drained", row, 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
